// File: rtl/seq_circuit_scheduler.sv
// Round-robin front end for a shared two-stage registered (a|b)&c datapath.
// Issues granted operands, tracks in-flight tags and sequences datapath resets.
module seq_circuit_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DP_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] op_a,
    input  logic [NUM_REQ-1:0] op_b,
    input  logic [NUM_REQ-1:0] op_c,
    output logic [NUM_REQ-1:0] gnt,
    input  logic               flush,
    output logic               dp_a,
    output logic               dp_b,
    output logic               dp_c,
    output logic               dp_reset,
    input  logic               dp_z,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_z,
    output logic               busy
);

    localparam int CNT_W = ID_W + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DPRST = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      rr_ptr_nxt_s;
    logic [ID_W-1:0]      gnt_id_s;
    logic                 gnt_vld_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [CNT_W-1:0]     cand_s;
    logic [CNT_W-1:0]     ptr_inc_s;
    logic [DP_LAT:0]      tag_vld_r;
    logic [ID_W-1:0]      tag_id_r [DP_LAT+1];
    logic                 dp_a_r;
    logic                 dp_b_r;
    logic                 dp_c_r;
    logic                 dp_reset_r;
    logic                 rsp_valid_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic                 rsp_z_r;

    // Next-state logic: drain only exits once every tag has left the pipeline
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (tag_vld_r == {(DP_LAT+1){1'b0}}) begin
                    state_nxt_s = ST_DPRST;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DPRST: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Round-robin search from the pointer; flush suppresses any grant
    always_comb begin
        gnt_vld_s    = 1'b0;
        gnt_id_s     = {ID_W{1'b0}};
        rr_ptr_nxt_s = rr_ptr_r;
        cand_s       = {CNT_W{1'b0}};
        ptr_inc_s    = {CNT_W{1'b0}};
        gnt_s        = {NUM_REQ{1'b0}};
        if ((state_r == ST_RUN) && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_s = {1'b0, rr_ptr_r} + CNT_W'(k);
                if (cand_s >= CNT_W'(NUM_REQ)) begin
                    cand_s = cand_s - CNT_W'(NUM_REQ);
                end else begin
                    cand_s = cand_s;
                end
                if (!gnt_vld_s && req[cand_s[ID_W-1:0]]) begin
                    gnt_vld_s = 1'b1;
                    gnt_id_s  = cand_s[ID_W-1:0];
                    ptr_inc_s = cand_s + {{ID_W{1'b0}}, 1'b1};
                    if (ptr_inc_s == CNT_W'(NUM_REQ)) begin
                        rr_ptr_nxt_s = {ID_W{1'b0}};
                    end else begin
                        rr_ptr_nxt_s = ptr_inc_s[ID_W-1:0];
                    end
                end else begin
                    gnt_vld_s = gnt_vld_s;
                end
            end
        end else begin
            gnt_vld_s = 1'b0;
        end
        if (gnt_vld_s) begin
            gnt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_s;
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    // Control state, pointer and datapath-reset register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_INIT;
            rr_ptr_r   <= {ID_W{1'b0}};
            dp_reset_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            dp_reset_r <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_DPRST);
        end
    end

    // Operand issue: bubbles drive zeros onto the datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_a_r <= 1'b0;
            dp_b_r <= 1'b0;
            dp_c_r <= 1'b0;
        end else if (gnt_vld_s) begin
            dp_a_r <= op_a[gnt_id_s];
            dp_b_r <= op_b[gnt_id_s];
            dp_c_r <= op_c[gnt_id_s];
        end else begin
            dp_a_r <= 1'b0;
            dp_b_r <= 1'b0;
            dp_c_r <= 1'b0;
        end
    end

    // Tag shift pipeline, one stage beyond the datapath latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_r <= {(DP_LAT+1){1'b0}};
            for (int i = 0; i <= DP_LAT; i++) begin
                tag_id_r[i] <= {ID_W{1'b0}};
            end
        end else begin
            tag_vld_r   <= {tag_vld_r[DP_LAT-1:0], gnt_vld_s};
            tag_id_r[0] <= gnt_id_s;
            for (int i = 1; i <= DP_LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Result capture aligned with the last tag stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_z_r     <= 1'b0;
        end else begin
            rsp_valid_r <= tag_vld_r[DP_LAT];
            rsp_id_r    <= tag_id_r[DP_LAT];
            rsp_z_r     <= dp_z;
        end
    end

    assign gnt       = gnt_s;
    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign dp_c      = dp_c_r;
    assign dp_reset  = dp_reset_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_z     = rsp_z_r;
    assign busy      = (state_r != ST_RUN) || (|tag_vld_r);

endmodule

// File: tb/tb_seq_circuit_scheduler.sv
// Directed bench for seq_circuit_scheduler with a behavioural two-stage datapath.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_seq_circuit_scheduler;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] req      = 4'b0000;
    logic [3:0] op_a     = 4'b0000;
    logic [3:0] op_b     = 4'b0000;
    logic [3:0] op_c     = 4'b0000;
    logic       flush    = 1'b0;
    logic [3:0] gnt;
    logic       dp_a;
    logic       dp_b;
    logic       dp_c;
    logic       dp_reset;
    logic       dp_z;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       rsp_z;
    logic       busy;

    logic       dp_s1_r  = 1'b0;
    logic       dp_z_r   = 1'b0;
    logic [3:0] z_of_req = 4'b1100;
    logic [3:0] exp_gnt;
    int         n_cmp    = 0;
    int         n_err    = 0;

    seq_circuit_scheduler #(.NUM_REQ(4), .ID_W(2), .DP_LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .gnt(gnt), .flush(flush), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
        .dp_reset(dp_reset), .dp_z(dp_z), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared datapath model: z = (a|b)&c after two registers, sync active-high reset
    always_ff @(posedge clk) begin
        if (dp_reset) begin
            dp_s1_r <= 1'b0;
            dp_z_r  <= 1'b0;
        end else begin
            dp_s1_r <= (dp_a | dp_b) & dp_c;
            dp_z_r  <= dp_s1_r;
        end
    end
    assign dp_z = dp_z_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",      32'(gnt),       32'h0);
        chk("rst_dp_reset", 32'(dp_reset),  32'h1);
        chk("rst_rsp_vld",  32'(rsp_valid), 32'h0);
        chk("rst_rsp_id",   32'(rsp_id),    32'h0);
        chk("rst_rsp_z",    32'(rsp_z),     32'h0);
        chk("rst_dp_abc",   32'({dp_a, dp_b, dp_c}), 32'h0);
        chk("rst_busy",     32'(busy),      32'h1);

        // Plan 1: release, idle
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("init_dp_reset", 32'(dp_reset), 32'h1);
        chk("init_busy",     32'(busy),     32'h1);
        chk("init_gnt",      32'(gnt),      32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk("idle_dp_reset", 32'(dp_reset),  32'h0);
            chk("idle_busy",     32'(busy),      32'h0);
            chk("idle_gnt",      32'(gnt),       32'h0);
            chk("idle_rsp_vld",  32'(rsp_valid), 32'h0);
        end

        // Plan 2: single req[2] (1,0,1)
        tick();
        req = 4'b0100; op_a = 4'b0100; op_b = 4'b0000; op_c = 4'b0100;
        @(negedge clk);
        chk("p2_gnt", 32'(gnt), 32'h4);
        for (int k = 1; k <= 5; k++) begin
            tick();
            req = 4'b0000;
            @(negedge clk);
            if (k == 1) begin
                chk("p2_dp_abc", 32'({dp_a, dp_b, dp_c}), 32'h5);
                chk("p2_busy",   32'(busy), 32'h1);
            end
            chk("p2_rsp_vld", 32'(rsp_valid), 32'(k == 4));
            if (k == 4) begin
                chk("p2_rsp_id", 32'(rsp_id), 32'h2);
                chk("p2_rsp_z",  32'(rsp_z),  32'h1);
            end
            if (k == 5) chk("p2_busy_end", 32'(busy), 32'h0);
        end

        // Plan 5: grant req[0] (pointer at 3), reset low at T+2 for one cycle
        tick();
        req = 4'b0001; op_a = 4'b0001; op_b = 4'b0000; op_c = 4'b0001;
        @(negedge clk);
        chk("p5_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        @(negedge clk);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("p5_rst_dp_reset", 32'(dp_reset),  32'h1);
        chk("p5_rst_busy",     32'(busy),      32'h1);
        chk("p5_rst_rsp_vld",  32'(rsp_valid), 32'h0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("p5_init_dp_reset", 32'(dp_reset),  32'h1);
        chk("p5_init_rsp_vld",  32'(rsp_valid), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk("p5_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Plan 3: all four requesting for 8 cycles; pointer restarts at 0
        op_a = 4'b1010; op_b = 4'b1110; op_c = 4'b1101;
        for (int c = 0; c < 13; c++) begin
            tick();
            req = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            exp_gnt = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            chk("p3_gnt", 32'(gnt), 32'(exp_gnt));
            chk("p3_rsp_vld", 32'(rsp_valid), 32'((c >= 4) && (c < 12)));
            if ((c >= 4) && (c < 12)) begin
                chk("p3_rsp_id", 32'(rsp_id), 32'((c - 4) % 4));
                chk("p3_rsp_z",  32'(rsp_z),  32'(z_of_req[(c - 4) % 4]));
            end
        end

        // Plan 6 setup: one grant to req[0] moves the pointer to 1
        tick();
        req = 4'b0001;
        @(negedge clk);
        chk("p6_setup_gnt", 32'(gnt), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            req = 4'b0000;
            @(negedge clk);
        end

        // Plan 6: req 1001 with pointer 1 -> 3 then 0
        for (int c = 0; c < 7; c++) begin
            tick();
            req = (c == 0) ? 4'b1001 : ((c == 1) ? 4'b0001 : 4'b0000);
            @(negedge clk);
            exp_gnt = (c == 0) ? 4'b1000 : ((c == 1) ? 4'b0001 : 4'b0000);
            chk("p6_gnt", 32'(gnt), 32'(exp_gnt));
            chk("p6_rsp_vld", 32'(rsp_valid), 32'((c == 4) || (c == 5)));
            if ((c == 4) || (c == 5)) begin
                chk("p6_rsp_id", 32'(rsp_id), (c == 4) ? 32'h3 : 32'h0);
                chk("p6_rsp_z",  32'(rsp_z),  (c == 4) ? 32'h1 : 32'h0);
            end
        end

        // Plan 4: two in flight (ids 2, 0), flush with req[1] pending
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0)                   req = 4'b0101;
            else if (c == 1)              req = 4'b0001;
            else if ((c >= 2) && (c <= 7)) req = 4'b0010;
            else                          req = 4'b0000;
            flush = (c == 2);
            @(negedge clk);
            if (c == 0)      exp_gnt = 4'b0100;
            else if (c == 1) exp_gnt = 4'b0001;
            else if (c == 7) exp_gnt = 4'b0010;
            else             exp_gnt = 4'b0000;
            chk("p4_gnt",      32'(gnt),      32'(exp_gnt));
            chk("p4_dp_reset", 32'(dp_reset), 32'(c == 6));
            chk("p4_busy",     32'(busy),     32'((c >= 1) && (c <= 10) && (c != 7)));
            chk("p4_rsp_vld",  32'(rsp_valid), 32'((c == 4) || (c == 5) || (c == 11)));
            if (c == 4) begin
                chk("p4_rsp_id_a", 32'(rsp_id), 32'h2);
                chk("p4_rsp_z_a",  32'(rsp_z),  32'h1);
            end
            if (c == 5) begin
                chk("p4_rsp_id_b", 32'(rsp_id), 32'h0);
                chk("p4_rsp_z_b",  32'(rsp_z),  32'h0);
            end
            if (c == 11) begin
                chk("p4_rsp_id_c", 32'(rsp_id), 32'h1);
                chk("p4_rsp_z_c",  32'(rsp_z),  32'h0);
            end
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_circuit_scheduler.md
Name: seq_circuit_scheduler

Overview:
Round-robin scheduler that shares one two-stage registered logic datapath (z = (a|b)&c, 2-cycle register latency, active-high synchronous reset) among NUM_REQ requesters. It arbitrates requests and registers the winning operand triple onto the datapath inputs. It tracks in-flight tags through a shift pipeline and returns each captured z with the requester ID. It also sequences datapath reset/flush, both at power-up and on command.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ
DP_LAT, 2, register latency of the shared datapath, input sample to valid z

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request; held until granted
op_a  input  NUM_REQ  per-requester operand a
op_b  input  NUM_REQ  per-requester operand b
op_c  input  NUM_REQ  per-requester operand c
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
flush  input  1  request pipeline drain plus datapath reset
dp_a  output  1  registered operand a to datapath
dp_b  output  1  registered operand b to datapath
dp_c  output  1  registered operand c to datapath
dp_reset  output  1  registered active-high sync reset to datapath
dp_z  input  1  datapath result
rsp_valid  output  1  one-cycle pulse, result valid
rsp_id  output  ID_W  requester index of result
rsp_z  output  1  captured dp_z
busy  output  1  high when state != RUN or any tag in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low. While reset is low: state=INIT, rr pointer=0, all tag valids=0, dp_a/b/c=0, dp_reset=1, rsp_valid=0, rsp_id=0, rsp_z=0, gnt=0.
- States:
  - INIT: dp_reset=1 for exactly one cycle after reset release, then RUN.
  - RUN: arbitrate.
  - DRAIN: no grants; go to DPRST when all tag valids are 0.
  - DPRST: dp_reset=1 for one cycle, then RUN.
- flush is sampled only in RUN. Asserting it moves RUN to DRAIN, and no grant is issued that same cycle (flush beats req). flush in other states is ignored.
- Arbitration (RUN only): search from rr pointer upward, modulo NUM_REQ. The first req[i]=1 gets gnt[i]=1. On grant, the pointer becomes (i+1) mod NUM_REQ; otherwise it is unchanged. At most one grant per cycle. Back-to-back grants every cycle are supported.
- Issue: at the edge ending grant cycle T, dp_a/b/c <= op_a/b/c[i] and tag stage0 <= {valid=1, id=i}. In cycles with no grant, dp_a/b/c <= 0 and the stage0 valid is 0.
- Tag pipeline: DP_LAT+1 stages, shifting every cycle, unconditionally.
- Result capture: at the edge ending cycle T+DP_LAT+1, rsp_z <= dp_z, rsp_id <= tag id, and rsp_valid <= tag valid. Consequences:
  - rsp_valid is high in cycle T+DP_LAT+2 (T+4 at default) for exactly one cycle.
  - rsp_z is invalid/held-undefined when rsp_valid=0; benches must not check it.
  - Results return in grant order. There is no backpressure, so consumers must accept every pulse.
- Bubbles (no grant) propagate as valid=0 and never produce rsp_valid.
- DRAIN exit: DRAIN completes only after the last in-flight result has been captured. dp_reset therefore never corrupts an outstanding result.
- Reset low mid-operation: all in-flight tags are discarded, no rsp_valid is emitted for them, and the block restarts in INIT.
- A requester whose req drops before grant is simply not served; no error is flagged.

Test Plan:
1. Release reset, no req -> dp_reset=1 in first cycle only; busy=1 then 0; gnt stays 0; rsp_valid never asserts.
2. Single req[2] with op (a,b,c)=(1,0,1) granted in cycle T -> gnt=4'b0100 in T; rsp_valid=1, rsp_id=2, rsp_z=1 in T+4 only.
3. req=4'b1111 held for 8 cycles, ops r0=(0,0,1), r1=(1,1,0), r2=(0,1,1), r3=(1,1,1) -> grants cycle 0,1,2,3,0,1,2,3. Responses with ids 0,1,2,3,0,... and z 0,0,1,1,... on consecutive cycles starting 4 cycles after first grant.
4. Two requests in flight, then flush pulse in RUN together with req[1] -> no grant that cycle; both outstanding responses delivered; dp_reset pulses one cycle after the last capture; req[1] granted on the first RUN cycle afterwards.
5. Grant req[0] at T, pull reset low at T+2 for one cycle -> no rsp_valid for that request; dp_reset=1, rr pointer=0 after release.
6. req=4'b1001 with pointer at 1 -> req[3] granted first, then req[0].
